// File: rtl/overflow_monitor_pkg.sv
// -----------------------------------------------------------------------------
// overflow_monitor_pkg
// Shared definitions for the overflow monitor slice:
//   - state_t      : snapshot handshake states (IDLE, HOLD)
//   - COUNT_W      : width of the upstream enable counter value
//   - snap_width() : width of one {wrap_count, count_in} snapshot
// -----------------------------------------------------------------------------
package overflow_monitor_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int snap_width(input int wrap_w);
        return wrap_w + COUNT_W;
    endfunction

endpackage

// File: rtl/overflow_monitor_edge_sat_counter.sv
// -----------------------------------------------------------------------------
// ovf_edge_sat_counter
// Rising-edge detect on the counter overflow level plus a saturating wrap
// counter with a sticky saturated flag.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : synchronous clear of wrap_count and saturated (wins over
//                 an event on the same edge); the edge detector is untouched
//   ovf_in      : overflow level from the counter
//   wrap_count  : registered event count, holds at all-ones
//   wrap_next   : value wrap_count takes at the next edge (for the alarm)
//   saturated   : sticky, set when wrap_count reaches all-ones
// -----------------------------------------------------------------------------
module ovf_edge_sat_counter
    import overflow_monitor_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              ovf_in,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WRAP_W-1:0] wrap_next,
    output logic              saturated
);

    logic ovf_d;
    logic ovf_event;
    logic saturated_next;

    assign ovf_event = ovf_in & ~ovf_d;

    always_comb begin
        wrap_next      = wrap_count;
        saturated_next = saturated;
        if (clear) begin
            wrap_next      = '0;
            saturated_next = 1'b0;
        end else if (ovf_event && (wrap_count != '1)) begin
            wrap_next = wrap_count + WRAP_W'(1);
            if (wrap_next == '1) begin
                saturated_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_d      <= 1'b0;
            wrap_count <= '0;
            saturated  <= 1'b0;
        end else begin
            ovf_d      <= ovf_in;
            wrap_count <= wrap_next;
            saturated  <= saturated_next;
        end
    end

endmodule

// File: rtl/overflow_monitor.sv
// -----------------------------------------------------------------------------
// overflow_monitor
// Converts the 4-bit counter's overflow level into a saturating wrap count,
// raises a registered threshold alarm, and hands out atomic snapshots of
// {wrap_count, count_in} over a valid/ready handshake.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : synchronous clear of wrap_count, saturated, alarm
//   ovf_in      : counter overflow level
//   count_in    : counter value
//   snap_req    : one-cycle snapshot request
//   snap_ready  : consumer accepts the held snapshot
//   snap_valid  : snapshot held and valid
//   snap_data   : {wrap_count, count_in} captured at request
//   snap_drop   : sticky, a request arrived while a snapshot was pending
//   wrap_count  : saturating overflow event count
//   saturated   : sticky, wrap_count reached all-ones
//   alarm       : wrap_count >= THRESH
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module overflow_monitor
    import overflow_monitor_pkg::*;
#(
    parameter int WRAP_W = 8,
    parameter int THRESH = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      ovf_in,
    input  logic [COUNT_W-1:0]        count_in,
    input  logic                      snap_req,
    input  logic                      snap_ready,
    output logic                      snap_valid,
    output logic [WRAP_W+COUNT_W-1:0] snap_data,
    output logic                      snap_drop,
    output logic [WRAP_W-1:0]         wrap_count,
    output logic                      saturated,
    output logic                      alarm
);

    localparam int SNAP_W = snap_width(WRAP_W);
    localparam logic [WRAP_W-1:0] THRESH_V = WRAP_W'(THRESH);

    logic [WRAP_W-1:0] wrap_next;
    state_t            state;

    ovf_edge_sat_counter #(
        .WRAP_W (WRAP_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .ovf_in     (ovf_in),
        .wrap_count (wrap_count),
        .wrap_next  (wrap_next),
        .saturated  (saturated)
    );

    // Compare against the next count so the alarm rises on the same edge as
    // the crossing increment; clear forces wrap_next to 0 and THRESH >= 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm <= 1'b0;
        end else begin
            alarm <= (wrap_next >= THRESH_V);
        end
    end

    // Snapshot captures the pre-update wrap_count, so a same-edge event is
    // seen only by the following snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            snap_data <= '0;
            snap_drop <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (snap_req) begin
                        snap_data <= SNAP_W'({wrap_count, count_in});
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (snap_req) begin
                        snap_drop <= 1'b1;
                    end else if (snap_ready) begin
                        snap_drop <= 1'b0;
                    end
                    if (snap_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign snap_valid = (state == HOLD);

endmodule

// File: tb/tb_overflow_monitor.sv
module tb_overflow_monitor;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        ovf_in;
    logic [3:0]  count_in;
    logic        snap_req;
    logic        snap_ready;
    logic        snap_valid;
    logic [11:0] snap_data;
    logic        snap_drop;
    logic [7:0]  wrap_count;
    logic        saturated;
    logic        alarm;

    logic        clear2;
    logic        ovf2;
    logic        snap_valid2;
    logic [5:0]  snap_data2;
    logic        snap_drop2;
    logic [1:0]  wrap_count2;
    logic        saturated2;
    logic        alarm2;

    int checks   = 0;
    int failures = 0;

    overflow_monitor #(.WRAP_W(8), .THRESH(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .ovf_in     (ovf_in),
        .count_in   (count_in),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .snap_drop  (snap_drop),
        .wrap_count (wrap_count),
        .saturated  (saturated),
        .alarm      (alarm)
    );

    overflow_monitor #(.WRAP_W(2), .THRESH(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear2),
        .ovf_in     (ovf2),
        .count_in   (4'd0),
        .snap_req   (1'b0),
        .snap_ready (1'b0),
        .snap_valid (snap_valid2),
        .snap_data  (snap_data2),
        .snap_drop  (snap_drop2),
        .wrap_count (wrap_count2),
        .saturated  (saturated2),
        .alarm      (alarm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        ovf_in = 1'b1;
        tick();
        ovf_in = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ovf_in = 1'b1;
        snap_req = 1'b1;
        tick();
        tick();
        checks++;
        if ({snap_valid, snap_data, snap_drop, wrap_count, saturated, alarm} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b data=%h drop=%0b wrap=%0d sat=%0b alarm=%0b want all 0",
                     snap_valid, snap_data, snap_drop, wrap_count, saturated, alarm);
        end
        checks++;
        if ({snap_valid2, snap_data2, snap_drop2, wrap_count2, saturated2, alarm2} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs_w2: got wrap=%0d sat=%0b alarm=%0b want 0", wrap_count2, saturated2, alarm2);
        end
        ovf_in = 1'b0;
        snap_req = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_level_once;
        ovf_in = 1'b1;
        repeat (5) tick();
        checks++;
        if (wrap_count !== 8'd1) begin
            failures++;
            $display("FAIL level_once: got wrap=%0d want 1", wrap_count);
        end
        ovf_in = 1'b0;
        tick();
    endtask

    task automatic test_pulses_alarm;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (wrap_count !== 8'd0) begin
            failures++;
            $display("FAIL clear_start: got wrap=%0d want 0", wrap_count);
        end
        for (int k = 1; k <= 10; k++) begin
            ovf_in = 1'b1;
            tick();
            checks++;
            if (wrap_count !== 8'(k) || alarm !== (k >= 10)) begin
                failures++;
                $display("FAIL pulse_%0d: got wrap=%0d alarm=%0b want wrap=%0d alarm=%0b",
                         k, wrap_count, alarm, k, (k >= 10));
            end
            ovf_in = 1'b0;
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (wrap_count !== 8'd0 || alarm !== 1'b0 || saturated !== 1'b0) begin
            failures++;
            $display("FAIL clear_alarm: got wrap=%0d alarm=%0b sat=%0b want 0 0 0", wrap_count, alarm, saturated);
        end
    endtask

    task automatic test_saturate;
        for (int k = 1; k <= 5; k++) begin
            ovf2 = 1'b1;
            tick();
            ovf2 = 1'b0;
            tick();
            checks++;
            if (wrap_count2 !== 2'((k > 3) ? 3 : k) || saturated2 !== (k >= 3)) begin
                failures++;
                $display("FAIL sat_pulse_%0d: got wrap=%0d sat=%0b want wrap=%0d sat=%0b",
                         k, wrap_count2, saturated2, (k > 3) ? 3 : k, (k >= 3));
            end
        end
        checks++;
        if (alarm2 !== 1'b1) begin
            failures++;
            $display("FAIL sat_alarm: got %0b want 1", alarm2);
        end
        clear2 = 1'b1;
        ovf2 = 1'b1;
        tick();
        clear2 = 1'b0;
        checks++;
        if (wrap_count2 !== 2'd0 || saturated2 !== 1'b0 || alarm2 !== 1'b0) begin
            failures++;
            $display("FAIL clear_vs_event: got wrap=%0d sat=%0b alarm=%0b want 0 0 0", wrap_count2, saturated2, alarm2);
        end
        tick();
        checks++;
        if (wrap_count2 !== 2'd0) begin
            failures++;
            $display("FAIL held_after_clear: got wrap=%0d want 0", wrap_count2);
        end
        ovf2 = 1'b0;
        tick();
    endtask

    task automatic test_snapshot;
        repeat (3) pulse();
        count_in = 4'd9;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if (snap_valid !== 1'b1 || snap_data !== 12'h039) begin
            failures++;
            $display("FAIL snap_capture: got valid=%0b data=%h want 1 039", snap_valid, snap_data);
        end
        ovf_in = 1'b1;
        tick();
        ovf_in = 1'b0;
        checks++;
        if (wrap_count !== 8'd4 || snap_data !== 12'h039) begin
            failures++;
            $display("FAIL snap_stable_event: got wrap=%0d data=%h want 4 039", wrap_count, snap_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (snap_valid !== 1'b1 || snap_data !== 12'h039) begin
                failures++;
                $display("FAIL snap_hold_%0d: got valid=%0b data=%h want 1 039", i, snap_valid, snap_data);
            end
        end
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        checks++;
        if (snap_valid !== 1'b0) begin
            failures++;
            $display("FAIL snap_accept: got valid=%0b want 0", snap_valid);
        end
        count_in = 4'd5;
        ovf_in = 1'b1;
        snap_req = 1'b1;
        tick();
        ovf_in = 1'b0;
        snap_req = 1'b0;
        checks++;
        if (snap_data !== 12'h045 || wrap_count !== 8'd5 || snap_valid !== 1'b1) begin
            failures++;
            $display("FAIL snap_same_edge: got data=%h wrap=%0d valid=%0b want 045 5 1", snap_data, wrap_count, snap_valid);
        end
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        snap_ready = 1'b1;
        count_in = 4'd2;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if (snap_valid !== 1'b1 || snap_data !== 12'h052) begin
            failures++;
            $display("FAIL b2b_first: got valid=%0b data=%h want 1 052", snap_valid, snap_data);
        end
        tick();
        checks++;
        if (snap_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: got valid=%0b want 0", snap_valid);
        end
        count_in = 4'd3;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if (snap_valid !== 1'b1 || snap_data !== 12'h053) begin
            failures++;
            $display("FAIL b2b_second: got valid=%0b data=%h want 1 053", snap_valid, snap_data);
        end
        tick();
        snap_ready = 1'b0;
        checks++;
        if (snap_valid !== 1'b0 || snap_drop !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got valid=%0b drop=%0b want 0 0", snap_valid, snap_drop);
        end
    endtask

    task automatic test_drop;
        count_in = 4'd7;
        snap_req = 1'b1;
        tick();
        tick();
        checks++;
        if (snap_drop !== 1'b1 || snap_valid !== 1'b1 || snap_data !== 12'h057) begin
            failures++;
            $display("FAIL drop_in_hold: got drop=%0b valid=%0b data=%h want 1 1 057", snap_drop, snap_valid, snap_data);
        end
        snap_ready = 1'b1;
        tick();
        checks++;
        if (snap_drop !== 1'b1 || snap_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_on_accept: got drop=%0b valid=%0b want 1 0", snap_drop, snap_valid);
        end
        snap_req = 1'b0;
        snap_ready = 1'b0;
        tick();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if (snap_drop !== 1'b1 || snap_valid !== 1'b1) begin
            failures++;
            $display("FAIL drop_sticky: got drop=%0b valid=%0b want 1 1", snap_drop, snap_valid);
        end
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        checks++;
        if (snap_drop !== 1'b0 || snap_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_clear: got drop=%0b valid=%0b want 0 0", snap_drop, snap_valid);
        end
    endtask

    task automatic test_async_reset;
        repeat (6) pulse();
        checks++;
        if (wrap_count !== 8'd11 || alarm !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_count: got wrap=%0d alarm=%0b want 11 1", wrap_count, alarm);
        end
        snap_req = 1'b1;
        tick();
        tick();
        snap_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({snap_valid, snap_data, snap_drop, wrap_count, saturated, alarm} !== 24'd0) begin
            failures++;
            $display("FAIL async_reset: got valid=%0b data=%h drop=%0b wrap=%0d alarm=%0b want all 0",
                     snap_valid, snap_data, snap_drop, wrap_count, alarm);
        end
        reset = 1'b0;
        tick();
        pulse();
        count_in = 4'd6;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if (wrap_count !== 8'd1 || snap_valid !== 1'b1 || snap_data !== 12'h016) begin
            failures++;
            $display("FAIL recovery: got wrap=%0d valid=%0b data=%h want 1 1 016", wrap_count, snap_valid, snap_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        ovf_in = 1'b0;
        count_in = 4'd0;
        snap_req = 1'b0;
        snap_ready = 1'b0;
        clear2 = 1'b0;
        ovf2 = 1'b0;
        test_reset();
        test_level_once();
        test_pulses_alarm();
        test_saturate();
        test_snapshot();
        test_back_to_back();
        test_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
